// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings, slot record and forwarding helper for the hazard unit
package pipe_pkg;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Slot records carry the widest supported register address; narrower ones are zero-extended.
  localparam int MAX_REG_ADDR_W = 8;
  typedef logic [MAX_REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_e;

  typedef struct packed {
    logic      valid;
    logic      we;
    logic      load;
    reg_addr_t dst;
  } slot_t;

  function automatic logic [1:0] fwd_from_slot(input logic [2:0] idx);
    case (idx)
      3'd1:    return FWD_EXMEM;
      3'd2:    return FWD_MEMWB;
      default: return FWD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - compares one ID source against every tracked slot
// youngest is the 1-based slot index of the nearest hit (0 when nothing hits).
module hazard_match
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3
) (
  input  slot_t [DEPTH-1:0]       slots,
  input  logic  [REG_ADDR_W-1:0]  src,
  input  logic                    src_re,
  output logic  [DEPTH-1:0]       hit,
  output logic  [2:0]             youngest,
  output logic                    youngest_load
);

  always_comb begin
    hit           = '0;
    youngest      = 3'd0;
    youngest_load = 1'b0;
    // Walk oldest to youngest so the nearest hit overwrites the rest.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit[k] = src_re && (src != '0) && slots[k].valid && slots[k].we &&
               (slots[k].dst == reg_addr_t'(src));
      if (hit[k]) begin
        youngest      = 3'(k + 1);
        youngest_load = slots[k].load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/bubble/flush, forwarding selects and halt drain for the 5-stage pipe
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int FWD        = 1,
  parameter int RF_BYPASS  = 1
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src0_addr,
  input  logic                  id_src0_re,
  input  logic [REG_ADDR_W-1:0] id_src1_addr,
  input  logic                  id_src1_re,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_dst_we,
  input  logic                  id_is_load,
  input  logic                  id_is_hlt,
  input  logic                  br_taken,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            fwd_sel0,
  output logic [1:0]            fwd_sel1,
  output logic                  hlt
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  slot_t [DEPTH-1:0] slots_q, slots_d;
  hazard_state_e     state_q, state_d;
  logic [1:0]        fwd_sel0_q, fwd_sel0_d, fwd_sel1_q, fwd_sel1_d;

  logic [DEPTH-1:0]  hit0, hit1, nofwd_mask;
  logic [2:0]        yng0, yng1;
  logic              yld0, yld1;
  logic              load_use, late0, late1, raw_haz, issue, slots_empty;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) u_match0 (
    .slots         (slots_q),
    .src           (id_src0_addr),
    .src_re        (id_src0_re),
    .hit           (hit0),
    .youngest      (yng0),
    .youngest_load (yld0)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) u_match1 (
    .slots         (slots_q),
    .src           (id_src1_addr),
    .src_re        (id_src1_re),
    .hit           (hit1),
    .youngest      (yng1),
    .youngest_load (yld1)
  );

  always_comb begin
    nofwd_mask  = '0;
    slots_empty = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      nofwd_mask[k] = (k < DEPTH - RF_BYPASS);
      if (slots_q[k].valid) slots_empty = 1'b0;
    end

    // With forwarding only a load in EX, or a writer past the forwarding paths, must wait.
    load_use = ((yng0 == 3'd1) && yld0) || ((yng1 == 3'd1) && yld1);
    late0    = (yng0 >= 3'd3) && (int'(yng0) <= DEPTH - RF_BYPASS);
    late1    = (yng1 >= 3'd3) && (int'(yng1) <= DEPTH - RF_BYPASS);
    raw_haz  = id_valid && ((FWD != 0) ? (load_use || late0 || late1)
                                       : (|((hit0 | hit1) & nofwd_mask)));

    flush  = br_taken;
    stall  = 1'b0;
    bubble = 1'b0;
    hlt    = 1'b0;
    case (state_q)
      RUN: begin
        stall  = raw_haz;
        bubble = raw_haz;
      end
      DRAIN: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      HALTED: begin
        stall = 1'b1;
        hlt   = 1'b1;
      end
      default: ;
    endcase
    if (flush) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end

    issue = id_valid && !stall && !flush && (state_q == RUN);

    state_d = state_q;
    case (state_q)
      RUN:     if (issue && id_is_hlt) state_d = DRAIN;
      DRAIN: begin
        if (br_taken)         state_d = RUN;
        else if (slots_empty) state_d = HALTED;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    slots_d = '0;
    if (issue && !id_is_hlt) begin
      slots_d[0].valid = 1'b1;
      slots_d[0].we    = id_dst_we;
      slots_d[0].load  = id_is_load;
      slots_d[0].dst   = reg_addr_t'(id_dst_addr);
    end
    for (int k = 1; k < DEPTH; k++) slots_d[k] = slots_q[k-1];
    // The branch sits in MEM; everything younger is squashed.
    if (flush) slots_d[1] = '0;

    fwd_sel0_d = FWD_NONE;
    fwd_sel1_d = FWD_NONE;
    if (issue) begin
      fwd_sel0_d = (FWD != 0) ? fwd_from_slot(yng0) : FWD_NONE;
      fwd_sel1_d = (FWD != 0) ? fwd_from_slot(yng1) : FWD_NONE;
    end else if (stall && !bubble) begin
      fwd_sel0_d = fwd_sel0_q;
      fwd_sel1_d = fwd_sel1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      slots_q    <= '0;
      fwd_sel0_q <= FWD_NONE;
      fwd_sel1_q <= FWD_NONE;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      fwd_sel0_q <= fwd_sel0_d;
      fwd_sel1_q <= fwd_sel1_d;
    end
  end

  assign fwd_sel0 = fwd_sel0_q;
  assign fwd_sel1 = fwd_sel1_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == RUN) && bubble && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((state_q != HALTED) && flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Keeps a shift register of in-flight destination tags for the stages after ID.
- Produces stall, bubble, flush and registered forwarding selects for the ID/EX boundary.
- Runs a halt-drain FSM that raises hlt only once all older instructions have retired.
- Supersedes the unconditional pipeline-register advance in the current CPU top.

Parameters:
REG_ADDR_W, 4, register address width (register 0 reads as zero and never causes a hazard)
DEPTH, 3, tracked post-ID slots: slot1=EX, slot2=MEM, slot3=WB; allowed range 3..6
FWD, 1, 1 enables forwarding; 0 resolves every RAW hazard by stalling
RF_BYPASS, 1, 1 means the register file returns same-cycle write data, so the WB slot never hazards
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clk  in  1  global clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_src0_addr  in  REG_ADDR_W  first source register
id_src0_re  in  1  first source is used
id_src1_addr  in  REG_ADDR_W  second source register
id_src1_re  in  1  second source is used
id_dst_addr  in  REG_ADDR_W  destination register
id_dst_we  in  1  instruction writes a register
id_is_load  in  1  instruction is a load (data available after MEM)
id_is_hlt  in  1  instruction is HLT
br_taken  in  1  branch taken, resolved in MEM
stall  out  1  hold PC and IF/ID
bubble  out  1  load a NOP into ID/EX
flush  out  1  clear IF/ID, ID/EX and EX/MEM control
fwd_sel0  out  2  operand 0 source in EX: 0=ID/EX, 1=EX/MEM result, 2=MEM/WB result
fwd_sel1  out  2  same encoding for operand 1
hlt  out  1  processor halted

Behaviour:
- Reset: all slots invalid, FSM=RUN, stall/bubble/flush/hlt=0, fwd_sel0/1=0. All registers clear asynchronously on rst_n low, including mid-drain.
- Slot shift each posedge:
  - slotk+1 <= slotk; slot DEPTH is discarded.
  - slot1 <= {valid, dst, we, load} of ID if issued (id_valid & ~stall & ~flush & FSM==RUN); otherwise slot1 is invalid.
- Match rule: source s matches slot k when the slot is valid, we=1, dst==s, s!=0 and the source's re=1.
- Hazard with FWD=1:
  - Match in slot1 with load=1 gives load-use: stall=1, bubble=1 for exactly 1 cycle.
  - Any other match in slot1 or slot2 gives no stall.
  - fwd_sel is registered at the issue edge: 1 if the match is in slot1, else 2 if the match is in slot2, else 0. The youngest match wins. Values hold across a stall; fwd_sel is 0 when a bubble issues.
- Hazard with FWD=0: any match in slots 1..DEPTH-RF_BYPASS gives stall=1, bubble=1. fwd_sel stays 0.
- Branch: br_taken makes flush=1 in the same cycle combinationally. Slot1 and slot2 (younger than MEM) are invalidated at the edge. flush has priority over stall; stall/bubble are forced 0 while flush=1.
- FSM:
  - RUN: HLT issued -> DRAIN. HLT is not entered in the slots.
  - DRAIN: stall=1, bubble=1. br_taken -> RUN (the HLT was younger and is squashed). All slots invalid -> HALTED.
  - HALTED: hlt=1, stall=1; sticky until reset.
- Latency: hazard outputs are combinational from ID inputs and slot state; fwd_sel has a 1-cycle register delay; hlt rises on the edge after the last slot empties.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds outputs stall_cnt and flush_cnt (CNT_W each).
  - stall_cnt increments on every cycle with bubble=1 while FSM==RUN.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones, reset to 0, and freeze in HALTED.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package pipe_pkg holds: the fwd_sel encoding constants (FWD_NONE=0, FWD_EXMEM=1, FWD_MEMWB=2); the FSM state encoding (RUN, DRAIN, HALTED); the slot struct {valid, we, load, dst}.
- One sub-module, hazard_match: combinational comparison of one source against all slots, returning hit-per-slot and youngest-hit index. It is instantiated twice.

Test Plan:
- ADD R1 issued, then SUB R2,R1,R3 next cycle (FWD=1) -> no stall; fwd_sel0=1 during SUB's EX. Same pattern with one independent instruction in between -> fwd_sel0=2.
- LW R4, then ADD R5,R4,R4 -> stall=1, bubble=1 for 1 cycle; then fwd_sel0=fwd_sel1=2.
- FWD=0, RF_BYPASS=1, ADD R1 then use of R1 -> stall for 2 cycles. Dependency on R0 -> never stalls.
- br_taken coincident with a load-use stall -> flush=1, stall=0; slot1 and slot2 invalid next cycle.
- HLT issued with 2 valid slots ahead -> DRAIN; hlt=1 three edges later. Repeat with br_taken during DRAIN -> FSM returns to RUN, hlt stays 0.
- rst_n pulsed low in DRAIN -> hlt=0, slots empty, fwd_sel=0 immediately. With HAZ_PERF_CNT_EN, 3 load-use stalls -> stall_cnt=3.
